mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single-port data memory and shares it between two requesters: instruction fetch (IF) and load/store (DATA).
- Fetch and data access are time-multiplexed onto one memory port. A configurable wait-state count covers slow memory.
- Sits between the control FSM / instruction-register path and the data memory.
- Requester side uses a req/gnt/done handshake. Memory side drives the address, write data and write enable, and samples read data.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, memory cycles per access (1..15); MEM_LAT=0 is an elaboration error
CNT_W, 4, wait counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
if_req  in  1  fetch request (level)
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle pulse: fetch accepted
if_done  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetch read data (held)
d_req  in  1  data request (level)
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_gnt  out  1  one-cycle pulse: data accepted
d_done  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DW  load data (held)
mem_addr  out  AW  memory address (registered)
mem_wdata  out  DW  memory write data (registered)
mem_we  out  1  memory write enable
mem_rdata  in  DW  memory read data
busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- While rst_n=0, all outputs are 0, including if_rdata, d_rdata, mem_addr and mem_wdata.
- States: IDLE, ACCESS, DONE.
- IDLE: samples if_req/d_req at each clock edge.
  - If either is high, pick a winner (see below).
  - Latch the winner's addr, wdata and we into mem_addr, mem_wdata and an internal we register.
  - Load the wait counter with MEM_LAT-1 and go to ACCESS.
- Winner selection, default: fixed priority, DATA over IF.
- ACCESS (first cycle):
  - The winner's gnt is high for exactly this cycle.
  - mem_we = latched we in the first ACCESS cycle only, so a store writes exactly once.
- ACCESS (every cycle): the counter decrements.
- ACCESS exit: when the counter is 0, capture mem_rdata into the winner's rdata register (loads and fetches only) and go to DONE.
  - A store leaves d_rdata unchanged.
- DONE: the winner's done is high for one cycle; then go to IDLE.
- Latency: req high in IDLE cycle T gives gnt at T+1, ACCESS for T+1..T+MEM_LAT, done at T+MEM_LAT+1, IDLE at T+MEM_LAT+2.
- Requester rule: after seeing done, drop req in the following cycle. A req still high there is taken as a new back-to-back request.
- req or addr changing after gnt is ignored; the access completes and done still pulses.
- The losing requester's req remains pending; it is served at the next IDLE unless a higher-priority request is present there.
- if_rdata and d_rdata hold their value until overwritten by the next completed read of that requester.
- rst_n asserted mid-operation: immediate return to IDLE, mem_we=0 at once, no gnt/done pulses. The aborted access is not resumed after reset is released.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, the requester not granted most recently wins. The last-grant register resets to IF, so DATA wins the first tie.
- Undefined: fixed DATA-over-IF priority; no last-grant register is synthesized.

Decomposition:
- Shared package cpu_pkg: arbiter state enum (ARB_IDLE, ARB_ACCESS, ARB_DONE) and requester IDs (ARB_SRC_IF=0, ARB_SRC_DATA=1).
- One natural sub-module: mem_wait_counter (load, decrement, zero flag, CNT_W wide).

Test Plan:
1. Reset: hold rst_n=0 with both reqs high -> all outputs 0, busy=0; release -> DATA granted first.
2. IF read, MEM_LAT=2, mem[0x100]=0xDEADBEEF, if_req at cycle 0 -> if_gnt cycle 1, if_done cycle 3, if_rdata=0xDEADBEEF, d_* stay 0.
3. Store d_addr=0x40, d_wdata=0x12345678 -> mem_we high exactly one cycle (cycle 1), d_done cycle 3, d_rdata unchanged; a following load of 0x40 returns 0x12345678.
4. if_req and d_req both rise at cycle 0, fixed priority -> d_gnt 1, d_done 3, if_gnt 5, if_done 7.
5. MEM_ARB_ROUND_ROBIN_EN defined, both reqs held high for 4 transactions -> grant order DATA, IF, DATA, IF.
6. rst_n pulsed low during the first ACCESS cycle of a store -> mem_we drops immediately, no d_done; after release, idle until a new req.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared arbiter types: FSM state and requester identifiers.
// Also fixes the legal wait-state range for the memory port.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_SRC_IF   = 1'b0,
        ARB_SRC_DATA = 1'b1
    } arb_src_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    function automatic arb_src_e arb_other(input arb_src_e s);
        return (s == ARB_SRC_IF) ? ARB_SRC_DATA : ARB_SRC_IF;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter covering memory wait states.
// Load has priority over decrement; the count stops at zero.
import cpu_pkg::*;

module mem_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch and load/store.
// MEM_ARB_ROUND_ROBIN_EN: alternate winners on ties (default DATA first).
import cpu_pkg::*;

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT must be 1..15");
    end
    if (MEM_LAT > (1 << CNT_W)) begin : g_cnt_chk
        $error("mem_port_arbiter: CNT_W too narrow for MEM_LAT");
    end

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    arb_state_e state_q;
    arb_src_e   src_q;
    arb_src_e   win;
    logic       we_q;
    logic       any_req;
    logic       start;
    logic       cnt_zero;

    assign any_req = if_req | d_req;
    assign start   = (state_q == ARB_IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_src_e last_q;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win = ARB_SRC_IF;
        unique case (1'b1)
            (if_req && d_req): win = arb_other(last_q);
            d_req:             win = ARB_SRC_DATA;
            default:           win = ARB_SRC_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ARB_SRC_IF;
        end else if (start) begin
            last_q <= win;
        end
    end
`else
    always_comb begin
        win = ARB_SRC_IF;
        unique case (1'b1)
            d_req:   win = ARB_SRC_DATA;
            default: win = ARB_SRC_IF;
        endcase
    end
`endif

    mem_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start),
        .load_val(LOAD_VAL),
        .dec     (state_q == ARB_ACCESS),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            src_q     <= ARB_SRC_IF;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_gnt  <= 1'b0;
            d_gnt   <= 1'b0;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            mem_we  <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        src_q   <= win;
                        state_q <= ARB_ACCESS;
                        if (win == ARB_SRC_DATA) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            we_q      <= d_we;
                            mem_we    <= d_we;
                            d_gnt     <= 1'b1;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            we_q      <= 1'b0;
                            if_gnt    <= 1'b1;
                        end
                    end
                end
                ARB_ACCESS: begin
                    // Read data is valid on the last wait cycle.
                    if (cnt_zero) begin
                        state_q <= ARB_DONE;
                        if (src_q == ARB_SRC_IF) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                d_rdata <= mem_rdata;
                            end
                            d_done <= 1'b1;
                        end
                    end
                end
                ARB_DONE: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model plus directed
// literal checks, then randomized request traffic.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Environment memory: untouched words read as init_word(index).
    logic [31:0] mem [1024];
    bit          written [1024];
    logic        tb_wr = 1'b0;
    logic [9:0]  tb_waddr = '0;
    logic [31:0] tb_wdat = '0;

    always @(posedge clk) begin
        if (tb_wr) begin
            mem[tb_waddr]     <= tb_wdat;
            written[tb_waddr] <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[9:0]]     <= mem_wdata;
            written[mem_addr[9:0]] <= 1'b1;
        end
    end

    assign mem_rdata = written[mem_addr[9:0]] ? mem[mem_addr[9:0]]
                                              : init_word(int'(mem_addr[9:0]));

    // Transaction-level model state.
    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc;
    bit          tx_on;
    int          g;
    bit          t_src;
    bit          t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    bit          pend;
    bit          last_src;
    logic [31:0] e_if_rd;
    logic [31:0] e_d_rd;
    logic [31:0] e_maddr;
    logic [31:0] model_mem [1024];
    bit          fd;
    int          order [4];
    int          n_ord;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    endtask

    task automatic model_reset();
        tx_on    = 1'b0;
        pend     = 1'b0;
        last_src = 1'b0;
        e_if_rd  = '0;
        e_d_rd   = '0;
        e_maddr  = '0;
    endtask

    // Decide what the edge closing cycle 'cyc' does with current inputs.
    task automatic model_edge();
        bit win;
        if (tx_on && cyc <= g + LAT) return;
        if (!(if_req || d_req)) return;
        if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win = ~last_src;
`else
            win = 1'b1;
`endif
        end else begin
            win = d_req;
        end
        tx_on    = 1'b1;
        g        = cyc + 1;
        t_src    = win;
        t_we     = win & d_we;
        t_addr   = win ? d_addr : if_addr;
        t_wdata  = d_wdata;
        pend     = t_we;
        last_src = win;
        e_maddr  = t_addr;
    endtask

    task automatic model_advance();
        if (pend && cyc == g + 1) begin
            model_mem[t_addr[9:0]] = t_wdata;
            pend = 1'b0;
        end
        if (tx_on && cyc == g + LAT && !t_we) begin
            if (t_src) e_d_rd  = model_mem[t_addr[9:0]];
            else       e_if_rd = model_mem[t_addr[9:0]];
        end
    endtask

    task automatic check_outputs();
        bit act;
        bit first;
        bit fin;
        act   = tx_on && cyc >= g && cyc <= g + LAT;
        first = tx_on && cyc == g;
        fin   = tx_on && cyc == g + LAT;
        chk("busy",     32'(busy),    32'(act));
        chk("if_gnt",   32'(if_gnt),  32'(first && !t_src));
        chk("d_gnt",    32'(d_gnt),   32'(first && t_src));
        chk("mem_we",   32'(mem_we),  32'(first && t_we));
        chk("if_done",  32'(if_done), 32'(fin && !t_src));
        chk("d_done",   32'(d_done),  32'(fin && t_src));
        chk("mem_addr", mem_addr,     e_maddr);
        chk("if_rdata", if_rdata,     e_if_rd);
        chk("d_rdata",  d_rdata,      e_d_rd);
        if (first && t_we) chk("mem_wdata", mem_wdata, t_wdata);
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        cyc++;
        model_advance();
        check_outputs();
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia,
                          input logic dr, input logic dw,
                          input logic [31:0] da, input logic [31:0] dd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic wait_idle();
        set_in(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            if (!(tx_on && cyc <= g + LAT)) break;
            step();
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = init_word(i);
        model_reset();
        cyc   = 0;
        rst_n = 1'b0;
        set_in(1, 32'h100, 1, 0, 32'h8, 0);

        // Preload 0x100 while held in reset.
        @(negedge clk);
        tb_wr = 1'b1; tb_waddr = 10'h100; tb_wdat = 32'hDEAD_BEEF;
        model_mem[10'h100] = 32'hDEAD_BEEF;
        @(negedge clk);
        tb_wr = 1'b0;
        @(negedge clk);
        chk("rst_busy",   32'(busy),           0);
        chk("rst_gnt",    32'({if_gnt, d_gnt}), 0);
        chk("rst_done",   32'({if_done, d_done}), 0);
        chk("rst_mem_we", 32'(mem_we),         0);
        chk("rst_maddr",  mem_addr,            0);
        chk("rst_mwdata", mem_wdata,           0);
        chk("rst_ifrd",   if_rdata,            0);
        chk("rst_drd",    d_rdata,             0);

        // Release with both requests pending: DATA wins.
        rst_n = 1'b1;
        step();
        chk("first_d_gnt",  32'(d_gnt),  1);
        chk("first_if_gnt", 32'(if_gnt), 0);
        wait_idle();

        // Fetch from 0x100.
        set_in(1, 32'h100, 0, 0, 0, 0);
        step();
        chk("fetch_gnt",   32'(if_gnt), 1);
        chk("fetch_d_gnt", 32'(d_gnt),  0);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("fetch_done",  32'(if_done), 1);
        chk("fetch_data",  if_rdata,     32'hDEAD_BEEF);
        chk("fetch_d_done", 32'(d_done), 0);
        wait_idle();

        // Store then load back.
        set_in(0, 0, 1, 1, 32'h40, 32'h1234_5678);
        step();
        chk("st_we1",  32'(mem_we), 1);
        chk("st_gnt",  32'(d_gnt),  1);
        chk("st_addr", mem_addr,    32'h40);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("st_we2",  32'(mem_we), 0);
        step();
        chk("st_done", 32'(d_done), 1);
        chk("st_rd_kept", d_rdata, init_word(8));
        wait_idle();
        set_in(0, 0, 1, 0, 32'h40, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("ld_done", 32'(d_done), 1);
        chk("ld_data", d_rdata, 32'h1234_5678);
        wait_idle();

        // Simultaneous requests.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        fd = 1'b0;
`else
        fd = 1'b1;
`endif
        set_in(1, 32'h100, 1, 0, 32'h40, 0);
        step();
        chk("tie_gnt1_d",  32'(d_gnt),  32'(fd));
        chk("tie_gnt1_if", 32'(if_gnt), 32'(!fd));
        if (fd) d_req = 1'b0; else if_req = 1'b0;
        step();
        step();
        chk("tie_done3", 32'(fd ? d_done : if_done), 1);
        step();
        step();
        chk("tie_gnt5", 32'(fd ? if_gnt : d_gnt), 1);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("tie_done7", 32'(fd ? if_done : d_done), 1);
        wait_idle();

        // Reset during the first cycle of a store.
        set_in(0, 0, 1, 1, 32'h80, 32'hCAFE_F00D);
        step();
        chk("ab_we_pre", 32'(mem_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_we_now", 32'(mem_we), 0);
        chk("ab_busy",   32'(busy),   0);
        chk("ab_gnt",    32'(d_gnt),  0);
        model_reset();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        check_outputs();
        for (int k = 0; k < 4; k++) step();
        chk("ab_no_done", 32'(d_done), 0);
        chk("ab_no_write", mem_rdata === 32'hCAFE_F00D ? 32'h1 : 32'h0, 0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Alternation from a fresh reset.
        n_ord = 0;
        set_in(1, 32'h10, 1, 0, 32'h20, 0);
        for (int k = 0; k < 40 && n_ord < 4; k++) begin
            step();
            if (d_gnt)  begin order[n_ord] = 1; n_ord++; end
            if (if_gnt) begin order[n_ord] = 0; n_ord++; end
        end
        chk("rr_count", n_ord, 4);
        for (int k = 0; k < 4; k++) chk("rr_order", order[k], (k % 2 == 0) ? 1 : 0);
        wait_idle();
`endif

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            set_in(1'($urandom_range(0, 1)), $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom);
            step();
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
